// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch program counter sequencer with redirect, halt and misaligned-target fault
module pc_sequencer #(
    parameter int unsigned      WIDTH        = 32,
    parameter int unsigned      STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_ready,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             pc_valid,
    output logic             fault,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // With STEP=1 the mask is zero, so no target can ever be misaligned.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fault_q, fault_d;
    logic             misaligned;

    assign misaligned  = |(load_target & ALIGN_MASK);
    assign pc_next_seq = pc_q + WIDTH'(STEP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALTED;
                end else if (load_en) begin
                    if (misaligned) begin
                        pc_d    = EXC_VECTOR;
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        pc_d = load_target;
                    end
                end else if (fetch_ready) begin
                    pc_d = pc_next_seq;
                end
            end
            HALTED: begin
                if (resume) begin
                    state_d = RUN;
                end
            end
            FAULT: begin
                pc_d = EXC_VECTOR;
                if (resume) begin
                    fault_d = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    assign pc       = pc_q;
    assign pc_valid = (state_q == RUN);
    assign fault    = fault_q;
    assign state    = state_q;

endmodule
